// File: rtl/exe_unit_mc_if.sv
// exe_unit_mc_if: decode-side request, flush and result-side handshake bundle for the execute stage.
// master = decode/writeback side, slave = execute stage.
interface exe_unit_mc_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      optype;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] offset;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            write_reg;
  logic            load_en;
  logic            store_en;
  logic [XLEN-1:0] store_data;
  logic            branch_taken;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport slave (
    input  flush, in_valid, optype, pc, data1, data2, immediate, offset, out_ready,
    output in_ready, out_valid, result, write_reg, load_en, store_en, store_data,
           branch_taken, target, illegal
  );

  modport master (
    output flush, in_valid, optype, pc, data1, data2, immediate, offset, out_ready,
    input  in_ready, out_valid, result, write_reg, load_en, store_en, store_data,
           branch_taken, target, illegal
  );
endinterface

// File: rtl/exe_unit_mc.sv
// exe_unit_mc: multi-cycle execute stage with registered, handshaked outputs and shift-add MUL/MULH.
// Define EXU_DIV_EN to add signed DIV/REM through a restoring divider.

`ifndef I_ADD
`define I_ADD   5'd0
`define I_ADDI  5'd1
`define I_SUB   5'd2
`define I_AND   5'd3
`define I_OR    5'd4
`define I_XOR   5'd5
`define I_LUI   5'd6
`define I_AUIPC 5'd7
`define I_LW    5'd8
`define I_SW    5'd9
`define I_JAL   5'd10
`define I_BEQ   5'd11
`define I_BNE   5'd12
`define I_BLT   5'd13
`define I_BGE   5'd14
`define I_MUL   5'd15
`define I_MULH  5'd16
`define I_DIV   5'd17
`define I_REM   5'd18
`endif

// state   | meaning
// ST_IDLE | accepting ops; single-cycle ops load outputs at the accept edge
// ST_MUL  | shift-add multiply, MUL_BITS multiplier bits per cycle
// ST_DIV  | restoring divide, one quotient bit per cycle
// ST_FIX  | sign-correct the magnitude result and load the output registers
module exe_unit_mc #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input logic          clk,
  input logic          rst,
  exe_unit_mc_if.slave bus
);
  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CW        = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
  state_t state, state_nxt;

  logic            vld, wr, ld, st, taken, ill;
  logic [XLEN-1:0] res, sdata, tgt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand, pp, prod;
  logic [XLEN-1:0]   mplier, abs1, abs2, fix_res;
  logic              neg, sel_hi;

  logic            accept, in_rdy, ld_single, ld_fix, is_mul_op;
  logic [XLEN-1:0] s_result, s_target;
  logic            s_wr, s_ld, s_st, s_br, s_ill, s_mc;

`ifdef EXU_DIV_EN
  logic            is_div_op, is_div, div_zero;
  logic [XLEN:0]   div_sh, div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0] div_val;
`endif

  always_comb begin
    s_result  = '0;
    s_target  = '0;
    s_wr      = 1'b0;
    s_ld      = 1'b0;
    s_st      = 1'b0;
    s_br      = 1'b0;
    s_ill     = 1'b0;
    s_mc      = 1'b0;
    is_mul_op = 1'b0;
`ifdef EXU_DIV_EN
    is_div_op = 1'b0;
`endif
    case (bus.optype)
      `I_ADD:   begin s_result = bus.data1 + bus.data2;     s_wr = 1'b1; end
      `I_ADDI:  begin s_result = bus.data1 + bus.immediate; s_wr = 1'b1; end
      `I_SUB:   begin s_result = bus.data1 - bus.data2;     s_wr = 1'b1; end
      `I_AND:   begin s_result = bus.data1 & bus.data2;     s_wr = 1'b1; end
      `I_OR:    begin s_result = bus.data1 | bus.data2;     s_wr = 1'b1; end
      `I_XOR:   begin s_result = bus.data1 ^ bus.data2;     s_wr = 1'b1; end
      `I_LUI:   begin s_result = bus.immediate;             s_wr = 1'b1; end
      `I_AUIPC: begin s_result = bus.pc + bus.immediate;    s_wr = 1'b1; end
      `I_LW:    begin s_result = bus.data1 + bus.offset; s_wr = 1'b1; s_ld = 1'b1; end
      `I_SW:    begin s_result = bus.data1 + bus.offset; s_st = 1'b1; end
      `I_JAL: begin
        s_result = bus.pc + XLEN'(4);
        s_target = bus.pc + bus.offset;
        s_wr     = 1'b1;
        s_br     = 1'b1;
      end
      `I_BEQ: begin s_target = bus.pc + bus.offset; s_br = (bus.data1 == bus.data2); end
      `I_BNE: begin s_target = bus.pc + bus.offset; s_br = (bus.data1 != bus.data2); end
      `I_BLT: begin s_target = bus.pc + bus.offset; s_br = ($signed(bus.data1) <  $signed(bus.data2)); end
      `I_BGE: begin s_target = bus.pc + bus.offset; s_br = ($signed(bus.data1) >= $signed(bus.data2)); end
      `I_MUL, `I_MULH: begin is_mul_op = 1'b1; s_mc = 1'b1; end
`ifdef EXU_DIV_EN
      `I_DIV, `I_REM:  begin is_div_op = 1'b1; s_mc = 1'b1; end
`endif
      default: s_ill = 1'b1;
    endcase
  end

  assign abs1 = bus.data1[XLEN-1] ? -bus.data1 : bus.data1;
  assign abs2 = bus.data2[XLEN-1] ? -bus.data2 : bus.data2;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op) state_nxt = ST_MUL;
`ifdef EXU_DIV_EN
        if (accept && is_div_op) state_nxt = ST_DIV;
`endif
      end
      ST_MUL, ST_DIV: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:         if (ld_fix) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_rdy = (state == ST_IDLE) && (!vld || bus.out_ready) && !rst && !bus.flush;
    ld_fix = (state == ST_FIX) && (!vld || bus.out_ready);
  end

  assign accept    = bus.in_valid && in_rdy;
  assign ld_single = accept && !s_mc;

  always_comb begin
    pp = '0;
    for (int b = 0; b < MUL_BITS; b++)
      if (mplier[b]) pp = pp + (mcand << b);
  end

`ifdef EXU_DIV_EN
  // acc holds {remainder, dividend/quotient}; quotient bits shift in from the right
  always_comb begin
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand[XLEN-1:0]};
    if (div_diff[XLEN]) div_step = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                div_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end
`endif

  always_comb begin
    prod    = neg ? -acc : acc;
    fix_res = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef EXU_DIV_EN
    div_val = sel_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (is_div) fix_res = (div_zero && !sel_hi) ? '1 : (neg ? -div_val : div_val);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
`ifdef EXU_DIV_EN
      is_div   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (accept && is_mul_op) begin
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, abs1};
      mplier <= abs2;
      neg    <= bus.data1[XLEN-1] ^ bus.data2[XLEN-1];
      sel_hi <= (bus.optype == `I_MULH);
      cnt    <= CW'(MUL_STEPS - 1);
`ifdef EXU_DIV_EN
      is_div <= 1'b0;
    end else if (accept && is_div_op) begin
      acc      <= {{XLEN{1'b0}}, abs1};
      mcand    <= {{XLEN{1'b0}}, abs2};
      sel_hi   <= (bus.optype == `I_REM);
      // remainder takes the dividend's sign, quotient the xor of both
      neg      <= (bus.optype == `I_REM) ? bus.data1[XLEN-1]
                                         : (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
      div_zero <= (bus.data2 == '0);
      is_div   <= 1'b1;
      cnt      <= CW'(XLEN - 1);
    end else if (state == ST_DIV) begin
      acc <= div_step;
      cnt <= cnt - 1'b1;
`endif
    end else if (state == ST_MUL) begin
      acc    <= acc + pp;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      cnt    <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld   <= 1'b0;
      res   <= '0;
      wr    <= 1'b0;
      ld    <= 1'b0;
      st    <= 1'b0;
      sdata <= '0;
      taken <= 1'b0;
      tgt   <= '0;
      ill   <= 1'b0;
    end else if (ld_single) begin
      vld   <= 1'b1;
      res   <= s_result;
      wr    <= s_wr;
      ld    <= s_ld;
      st    <= s_st;
      sdata <= bus.data2;
      taken <= s_br;
      tgt   <= s_target;
      ill   <= s_ill;
    end else if (ld_fix) begin
      vld   <= 1'b1;
      res   <= fix_res;
      wr    <= 1'b1;
      ld    <= 1'b0;
      st    <= 1'b0;
      taken <= 1'b0;
      tgt   <= '0;
      ill   <= 1'b0;
    end else begin
      if (vld && bus.out_ready) vld <= 1'b0;
      if (accept) sdata <= bus.data2;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = vld;
  assign bus.result       = res;
  assign bus.write_reg    = wr;
  assign bus.load_en      = ld;
  assign bus.store_en     = st;
  assign bus.store_data   = sdata;
  assign bus.branch_taken = taken;
  assign bus.target       = tgt;
  assign bus.illegal      = ill;
endmodule

// File: tb/tb_exe_unit_mc.sv
// tb_exe_unit_mc: directed self-checking bench for the exe_unit_mc execute stage.
// Expected values are hand-computed constants; DIV/REM cases run when EXU_DIV_EN is defined.
module tb_exe_unit_mc;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_ADD = 5'd0,  OP_ADDI = 5'd1, OP_SUB = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4,  OP_XOR  = 5'd5, OP_LUI = 5'd6,  OP_AUIPC = 5'd7;
  localparam logic [4:0] OP_LW  = 5'd8,  OP_SW   = 5'd9, OP_JAL = 5'd10, OP_BEQ = 5'd11;
  localparam logic [4:0] OP_BNE = 5'd12, OP_BLT  = 5'd13, OP_BGE = 5'd14, OP_MUL = 5'd15;
  localparam logic [4:0] OP_MULH = 5'd16, OP_DIV = 5'd17, OP_REM = 5'd18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  exe_unit_mc_if #(.XLEN(XLEN)) bus ();

  exe_unit_mc #(.XLEN(XLEN), .MUL_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.optype = OP_ADD;
    bus.pc = '0; bus.data1 = '0; bus.data2 = '0; bus.immediate = '0; bus.offset = '0;
    bus.out_ready = 1'b1;
  endtask

  // present one op at a negedge, hold until accepted, return 1 time unit after the accept edge
  task automatic issue(input logic [4:0] op, input logic [31:0] d1, d2, imm, pc, off);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.optype = op; bus.data1 = d1; bus.data2 = d2;
    bus.immediate = imm; bus.pc = pc; bus.offset = off;
    #1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // count edges after the accept edge until out_valid; note any cycle with in_ready high meanwhile
  task automatic wait_out(output int edges, output logic ir_bad);
    edges = 0; ir_bad = 1'b0;
    while (!bus.out_valid && edges < 60) begin
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    checks++;
    if (bus.result !== 32'h0 || bus.target !== 32'h0 || bus.store_data !== 32'h0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL reset_regs: result=%h target=%h store_data=%h illegal=%0b want all 0",
                         bus.result, bus.target, bus.store_data, bus.illegal);
    end
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    issue(OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h0, 32'h0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.result !== 32'd2) begin errors++; $display("FAIL addi_result: got %h want 00000002", bus.result); end
    checks++; if (bus.write_reg !== 1'b1 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL addi_flags: write_reg=%0b illegal=%0b want 1 0", bus.write_reg, bus.illegal); end
  endtask

  // back-to-back single-cycle ops, one accepted every cycle
  task automatic test_alu();
    logic [4:0]  ops [9];
    logic [31:0] d1s [9];
    logic [31:0] d2s [9];
    logic [31:0] ims [9];
    logic [31:0] pcs [9];
    logic [31:0] ofs [9];
    logic [31:0] exp [9];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LUI, OP_AUIPC, OP_LW, OP_JAL};
    d1s = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0};
    d2s = '{32'd1, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'h0, 32'h0, 32'h0, 32'h0};
    ims = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 32'h0000_1000, 32'h0, 32'h0};
    pcs = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h200};
    ofs = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd8, 32'h40};
    exp = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
            32'h1234_5000, 32'h0000_1100, 32'h0000_0004, 32'h0000_0204};
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], d1s[i], d2s[i], ims[i], pcs[i], ofs[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i]) begin
        errors++; $display("FAIL alu_%0d op=%0d: valid=%0b result=%h want 1 %h", i, ops[i], bus.out_valid, bus.result, exp[i]);
      end
      if (ops[i] == OP_LW) begin
        checks++;
        if (bus.load_en !== 1'b1 || bus.store_en !== 1'b0) begin
          errors++; $display("FAIL lw_flags: load_en=%0b store_en=%0b want 1 0", bus.load_en, bus.store_en); end
      end
    end
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.target !== 32'h240 || bus.write_reg !== 1'b1) begin
      errors++; $display("FAIL jal_flags: taken=%0b target=%h write_reg=%0b want 1 00000240 1",
                         bus.branch_taken, bus.target, bus.write_reg);
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [6];
    logic [31:0] d1s [6];
    logic [31:0] d2s [6];
    logic [31:0] exp [6];
    int edges;
    logic ir_bad;
    ops = '{OP_MUL, OP_MULH, OP_MUL, OP_MULH, OP_MUL, OP_MULH};
    d1s = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD, 32'd12345, 32'h1234_5678};
    d2s = '{32'd2, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd678, 32'h10};
    exp = '{32'hFFFF_FFFE, 32'h4000_0000, 32'h0, 32'hFFFF_FFFF, 32'd8369910, 32'h1};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], d1s[i], d2s[i], 32'h0, 32'h0, 32'h0);
      wait_out(edges, ir_bad);
      checks++; if (edges != 17) begin errors++; $display("FAIL mul_latency_%0d: got %0d edges want 17", i, edges); end
      checks++; if (ir_bad !== 1'b0) begin errors++; $display("FAIL mul_in_ready_%0d: in_ready high while busy, want 0", i); end
      checks++;
      if (bus.result !== exp[i] || bus.write_reg !== 1'b1) begin
        errors++; $display("FAIL mul_result_%0d: result=%h write_reg=%0b want %h 1", i, bus.result, bus.write_reg, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [4:0]  ops [7];
    logic [31:0] d1s [7];
    logic [31:0] d2s [7];
    logic        exp [7];
    ops = '{OP_BLT, OP_BGE, OP_BLT, OP_BGE, OP_BEQ, OP_BNE, OP_BNE};
    d1s = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd7, 32'd7, 32'd7};
    d2s = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd7, 32'd7, 32'd8};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], d1s[i], d2s[i], 32'h0, 32'h100, 32'h20);
      checks++;
      if (bus.branch_taken !== exp[i]) begin
        errors++; $display("FAIL branch_taken_%0d: got %0b want %0b", i, bus.branch_taken, exp[i]); end
      checks++;
      if (bus.target !== 32'h120 || bus.write_reg !== 1'b0 || bus.result !== 32'h0) begin
        errors++; $display("FAIL branch_fields_%0d: target=%h write_reg=%0b result=%h want 00000120 0 00000000",
                           i, bus.target, bus.write_reg, bus.result);
      end
    end
  endtask

  task automatic test_backpressure();
    issue(OP_ADD, 32'd1, 32'd2, 32'h0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.optype = OP_SUB; bus.data1 = 32'd9; bus.data2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd3 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: valid=%0b result=%h in_ready=%0b want 1 00000003 0",
                           i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
      errors++; $display("FAIL bp_next_result: valid=%0b result=%h want 1 00000005", bus.out_valid, bus.result); end
  endtask

  task automatic test_flush();
    logic seen;
    issue(OP_MUL, 32'd3, 32'd4, 32'h0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_recover_in_ready: got %0b want 1", bus.in_ready); end
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_late_result: out_valid rose after flush, want 0"); end
    issue(OP_SW, 32'h1000, 32'hAB, 32'h0, 32'h0, 32'd8);
    checks++;
    if (bus.result !== 32'h1008 || bus.store_data !== 32'hAB) begin
      errors++; $display("FAIL sw_result: result=%h store_data=%h want 00001008 000000ab", bus.result, bus.store_data); end
    checks++;
    if (bus.store_en !== 1'b1 || bus.write_reg !== 1'b0 || bus.load_en !== 1'b0) begin
      errors++; $display("FAIL sw_flags: store_en=%0b write_reg=%0b load_en=%0b want 1 0 0",
                         bus.store_en, bus.write_reg, bus.load_en); end
    // op presented in the same cycle as flush must be dropped
    @(negedge clk);
    bus.in_valid = 1'b1; bus.optype = OP_ADD; bus.data1 = 32'd1; bus.data2 = 32'd1; bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_accept_in_ready: got %0b want 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_dropped: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    issue(5'd31, 32'd1, 32'd2, 32'h0, 32'h100, 32'h20);
    checks++;
    if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b1 || bus.result !== 32'h0) begin
      errors++; $display("FAIL illegal_31: illegal=%0b valid=%0b result=%h want 1 1 00000000",
                         bus.illegal, bus.out_valid, bus.result); end
    checks++;
    if (bus.write_reg !== 1'b0 || bus.load_en !== 1'b0 || bus.store_en !== 1'b0 || bus.branch_taken !== 1'b0) begin
      errors++; $display("FAIL illegal_enables: wr=%0b ld=%0b st=%0b br=%0b want 0 0 0 0",
                         bus.write_reg, bus.load_en, bus.store_en, bus.branch_taken); end
    issue(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0);
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %0b want 0", bus.illegal); end
`ifndef EXU_DIV_EN
    issue(OP_DIV, 32'd7, 32'd2, 32'h0, 32'h0, 32'h0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL div_disabled_illegal: illegal=%0b valid=%0b want 1 1", bus.illegal, bus.out_valid); end
    issue(OP_REM, 32'd7, 32'd2, 32'h0, 32'h0, 32'h0);
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL rem_disabled_illegal: got %0b want 1", bus.illegal); end
`endif
  endtask

`ifdef EXU_DIV_EN
  task automatic test_div();
    logic [4:0]  ops [8];
    logic [31:0] d1s [8];
    logic [31:0] d2s [8];
    logic [31:0] exp [8];
    int edges;
    logic ir_bad;
    ops = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM};
    d1s = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    d2s = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0};
    exp = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], d1s[i], d2s[i], 32'h0, 32'h0, 32'h0);
      wait_out(edges, ir_bad);
      checks++; if (edges != 33) begin errors++; $display("FAIL div_latency_%0d: got %0d edges want 33", i, edges); end
      checks++; if (ir_bad !== 1'b0) begin errors++; $display("FAIL div_in_ready_%0d: in_ready high while busy, want 0", i); end
      checks++;
      if (bus.result !== exp[i]) begin
        errors++; $display("FAIL div_result_%0d: got %h want %h", i, bus.result, exp[i]); end
    end
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_addi();
    test_alu();
    test_mul();
    test_branch();
    test_backpressure();
    test_flush();
    test_illegal();
`ifdef EXU_DIV_EN
    test_div();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
